mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter DATA_W, 15, data word width.
REQ-002 Parameter ADDR_W, 3, address width; depth = 2**ADDR_W = 8 words.
REQ-003 Single clock domain; reset is synchronous and active-high.
REQ-004 clk  in  1  system clock, all state updates on rising edge.
REQ-005 rst  in  1  synchronous active-high reset, sampled on rising clk.
REQ-006 cmd_valid  in  1  command request.
REQ-007 cmd_ready  out  1  controller can accept a command this cycle.
REQ-008 cmd_write  in  1  1 = write, 0 = read.
REQ-009 cmd_addr  in  ADDR_W  target word address.
REQ-010 cmd_wdata  in  DATA_W  write data.
REQ-011 rsp_valid  out  1  response available.
REQ-012 rsp_ready  in  1  consumer accepts the response.
REQ-013 rsp_rdata  out  DATA_W  read data, or read-back data for writes.
REQ-014 rsp_err  out  1  write-verify mismatch flag, always 0 for reads.
REQ-015 fill_start  in  1  one-cycle pulse that starts a whole-memory fill.
REQ-016 fill_value  in  DATA_W  fill word, latched with fill_start.
REQ-017 fill_done  out  1  one-cycle pulse when the fill completes.
REQ-018 busy  out  1  high in any state other than IDLE.
REQ-019 err_count  out  8  saturating count of write-verify mismatches.
REQ-020 mem_addr / mem_we / mem_wdata  out  ADDR_W/1/DATA_W  registered drive to memory_module addr/we/in_data.
REQ-021 mem_rdata  in  DATA_W  memory_module out_data.

Function
REQ-022 The memory model has a synchronous write and a registered read; mem_rdata shows the addressed word, or the word just written, one edge after the address is presented.
REQ-023 The FSM states are IDLE, ACCESS, CAPTURE, RESP and FILL.
REQ-024 cmd_ready is (state==IDLE) && !fill_start, and a command is accepted on the edge where cmd_valid && cmd_ready.
REQ-025 The accept edge E0 latches the command, moves the FSM to ACCESS, and registers mem_addr, mem_we=cmd_write and mem_wdata.
REQ-026 ACCESS lasts exactly one cycle; mem_we is high for exactly one cycle per write command, and reads hold mem_we=0.
REQ-027 CAPTURE is the cycle after E1; at edge E2 the block registers rsp_rdata<=mem_rdata, sets rsp_valid=1, and enters RESP, giving a fixed latency of 2 edges from acceptance.
REQ-028 For writes, rsp_err = (mem_rdata != latched wdata) is registered at E2, and err_count increments on mismatch and saturates at 255.
REQ-029 In RESP, rsp_valid, rsp_rdata and rsp_err are held stable until rsp_valid && rsp_ready; rsp_valid then clears on that edge and the FSM returns to IDLE.
REQ-030 No new memory access occurs while in RESP; cmd_ready stays 0 until the FSM is back in IDLE, so there is at most one command outstanding.
REQ-031 fill_start is accepted only in IDLE; it is ignored in all other states.
REQ-032 If fill_start and cmd_valid are both high in IDLE, the fill wins and the command is not accepted.
REQ-033 FILL writes fill_value to addresses 0..7 in ascending order, one per cycle; mem_we is high for exactly 8 consecutive cycles.
REQ-034 The fill address counter wraps 7->0 to terminate; on the edge after the address-7 write, fill_done pulses for 1 cycle and the FSM returns to IDLE.
REQ-035 FILL generates no rsp_valid and does not change err_count.
REQ-036 mem_addr and mem_wdata hold their last values when mem_we=0.

Reset
REQ-037 rst at a rising edge forces IDLE from any state, including mid-ACCESS, RESP or FILL; any in-progress operation is abandoned with no response.
REQ-038 The reset values are cmd_ready=1 after release, rsp_valid=0, rsp_rdata=0, rsp_err=0, fill_done=0, busy=0, err_count=0, mem_we=0, mem_addr=0 and mem_wdata=0.
REQ-039 memory_module shares rst and clears to 0; the controller assumes all words read 0 after reset.

Verification
REQ-040 After reset, read addr 3 -> rsp_valid 2 edges after acceptance, rsp_rdata=0x0000, rsp_err=0.
REQ-041 Write 0x0ABB to addr 0, then read addr 0 -> write response rsp_rdata=0x0ABB, rsp_err=0; read returns 0x0ABB; exactly one mem_we cycle.
REQ-042 fill_start with fill_value=0x7F81, then read addrs 0..7 -> all return 0x7F81; mem_we high 8 cycles; exactly one fill_done pulse.
REQ-043 Hold rsp_ready=0 for 5 cycles after a read of addr 2 -> rsp_valid, rsp_rdata and rsp_err stable; cmd_ready=0; no mem_we and no mem_addr change.
REQ-044 Bench forces mem_rdata=0 and writes 0x1381 -> rsp_err=1 and err_count=1; after 300 such writes err_count=255.
REQ-045 Assert rst while the fill is writing addr 4 -> next cycle mem_we=0, busy=0, no fill_done, and cmd_ready=1 once rst is low.

Source files
------------

// File: rtl/mem_access_ctrl_if.sv
// Command/response handshake bundle between a requester and mem_access_ctrl.
// The requester uses the master modport and the controller uses the slave modport.
interface mem_access_ctrl_if #(
    parameter int DATA_W = 15,
    parameter int ADDR_W = 3
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Single-outstanding read/write-verify controller for an 8-word memory with
// registered read, plus a whole-memory fill engine.
module mem_access_ctrl #(
    parameter int DATA_W = 15,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    mem_access_ctrl_if.slave  bus,
    input  logic              fill_start,
    input  logic [DATA_W-1:0] fill_value,
    output logic              fill_done,
    output logic              busy,
    output logic [7:0]        err_count,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [2:0] {IDLE, ACCESS, CAPTURE, RESP, FILL} state_t;

    state_t            state;
    logic              write_p0;
    logic [DATA_W-1:0] wdata_p0;
    logic              rsp_valid_p2;
    logic [DATA_W-1:0] rsp_rdata_p2;
    logic              rsp_err_p2;
    logic              accept;
    logic              fill_go;
    logic              verify_miss;
    logic [ADDR_W-1:0] fill_next;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign fill_go       = (state == IDLE) && fill_start;
    assign bus.cmd_ready = (state == IDLE) && !fill_start;
    assign accept        = bus.cmd_valid && bus.cmd_ready;
    assign busy          = (state != IDLE);
    assign verify_miss   = write_p0 && (mem_rdata != wdata_p0);
    // Fill terminates when the address counter wraps back to 0.
    assign fill_next     = mem_addr + ADDR_W'(1);

    assign bus.rsp_valid = rsp_valid_p2;
    assign bus.rsp_rdata = rsp_rdata_p2;
    assign bus.rsp_err   = rsp_err_p2;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            rsp_valid_p2 <= 1'b0;
            rsp_rdata_p2 <= '0;
            rsp_err_p2   <= 1'b0;
            fill_done    <= 1'b0;
            err_count    <= 8'd0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
        end else begin
            fill_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (fill_go) begin
                        state     <= FILL;
                        mem_addr  <= '0;
                        mem_we    <= 1'b1;
                        mem_wdata <= fill_value;
                    end else if (accept) begin
                        state    <= ACCESS;
                        write_p0 <= bus.cmd_write;
                        wdata_p0 <= bus.cmd_wdata;
                        mem_addr <= bus.cmd_addr;
                        mem_we   <= bus.cmd_write;
                        if (bus.cmd_write) begin
                            mem_wdata <= bus.cmd_wdata;
                        end
                    end
                end
                // Memory samples address/write this cycle; read data appears after E1.
                ACCESS: begin
                    mem_we <= 1'b0;
                    state  <= CAPTURE;
                end
                CAPTURE: begin
                    rsp_rdata_p2 <= mem_rdata;
                    rsp_valid_p2 <= 1'b1;
                    rsp_err_p2   <= verify_miss;
                    if (verify_miss) begin
                        err_count <= sat_inc(err_count);
                    end
                    state <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_p2 <= 1'b0;
                        state        <= IDLE;
                    end
                end
                FILL: begin
                    if (fill_next == '0) begin
                        mem_we    <= 1'b0;
                        fill_done <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        mem_addr <= fill_next;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: vector table, scoreboard of expected responses,
// and directed sequences for fill, back-pressure, verify errors and reset.
module tb_mem_access_ctrl;
    localparam int DATA_W = 15;
    localparam int ADDR_W = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_access_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    logic              fill_start;
    logic [DATA_W-1:0] fill_value;
    logic              fill_done;
    logic              busy;
    logic [7:0]        err_count;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    mem_access_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .fill_start (fill_start),
        .fill_value (fill_value),
        .fill_done  (fill_done),
        .busy       (busy),
        .err_count  (err_count),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // Memory: synchronous write, registered read with write-through, cleared by rst.
    logic [DATA_W-1:0] mem [8];
    logic [DATA_W-1:0] mem_q;
    logic              force_zero;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) mem[i] <= '0;
            mem_q <= '0;
        end else begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            mem_q <= mem_we ? mem_wdata : mem[mem_addr];
        end
    end
    assign mem_rdata = force_zero ? '0 : mem_q;

    int checks   = 0;
    int failures = 0;
    int we_cnt   = 0;
    int done_cnt = 0;

    always @(posedge clk) begin
        if (mem_we) we_cnt <= we_cnt + 1;
        if (fill_done) done_cnt <= done_cnt + 1;
    end

    typedef struct {
        logic [DATA_W-1:0] rdata;
        logic              err;
    } rsp_t;
    rsp_t sb_q[$];

    typedef struct {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] exp_rdata;
        logic              exp_err;
    } vec_t;
    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Response monitor: every completed handshake must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && bus.rsp_valid && bus.rsp_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                rsp_t e;
                e = sb_q.pop_front();
                check("rsp_rdata", 32'(bus.rsp_rdata), 32'(e.rdata));
                check("rsp_err", 32'(bus.rsp_err), 32'(e.err));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one command; returns edges from acceptance until rsp_valid is seen.
    task automatic send(input logic wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd,
                        input logic [DATA_W-1:0] er, input logic ee, output int lat);
        int   n;
        rsp_t e;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = a;
        bus.cmd_wdata = wd;
        #1;
        n = 0;
        while (!bus.cmd_ready && n < 50) begin
            tick();
            n++;
        end
        if (!bus.cmd_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
            bus.cmd_valid = 1'b0;
            lat = -1;
            return;
        end
        e.rdata = er;
        e.err   = ee;
        sb_q.push_back(e);
        tick();
        bus.cmd_valid = 1'b0;
        lat = 0;
        while (!bus.rsp_valid && lat < 50) begin
            tick();
            lat++;
        end
    endtask

    initial begin
        int lat;
        int n;
        int pre_we;
        int pre_done;

        rst           = 1'b1;
        force_zero    = 1'b0;
        fill_start    = 1'b0;
        fill_value    = '0;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.rsp_ready = 1'b1;

        vecs[0]  = '{1'b0, 3'd3, 15'h0000, 15'h0000, 1'b0};
        vecs[1]  = '{1'b1, 3'd0, 15'h0ABB, 15'h0ABB, 1'b0};
        vecs[2]  = '{1'b0, 3'd0, 15'h0000, 15'h0ABB, 1'b0};
        vecs[3]  = '{1'b1, 3'd5, 15'h1234, 15'h1234, 1'b0};
        vecs[4]  = '{1'b0, 3'd5, 15'h0000, 15'h1234, 1'b0};
        vecs[5]  = '{1'b1, 3'd7, 15'h7FFF, 15'h7FFF, 1'b0};
        vecs[6]  = '{1'b0, 3'd7, 15'h0000, 15'h7FFF, 1'b0};
        vecs[7]  = '{1'b0, 3'd6, 15'h0000, 15'h0000, 1'b0};
        vecs[8]  = '{1'b1, 3'd0, 15'h0001, 15'h0001, 1'b0};
        vecs[9]  = '{1'b0, 3'd0, 15'h0000, 15'h0001, 1'b0};
        vecs[10] = '{1'b1, 3'd3, 15'h0000, 15'h0000, 1'b0};
        vecs[11] = '{1'b0, 3'd3, 15'h0000, 15'h0000, 1'b0};

        repeat (3) tick();
        rst = 1'b0;
        #1;
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
        check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        check("rst_fill_done", 32'(fill_done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);

        for (int i = 0; i < 12; i++) begin
            pre_we = we_cnt;
            send(vecs[i].write, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_err, lat);
            check("latency", 32'(lat), 32'd2);
            tick();
            check("rsp_cleared", 32'(bus.rsp_valid), 32'd0);
            check("we_cycles", 32'(we_cnt - pre_we), vecs[i].write ? 32'd1 : 32'd0);
        end
        check("err_count_clean", 32'(err_count), 32'd0);

        // Fill with a simultaneous command: the fill takes priority.
        pre_we        = we_cnt;
        pre_done      = done_cnt;
        fill_value    = 15'h7F81;
        fill_start    = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = 3'd2;
        bus.cmd_wdata = 15'h1111;
        #1;
        check("fill_prio_ready", 32'(bus.cmd_ready), 32'd0);
        tick();
        fill_start    = 1'b0;
        bus.cmd_valid = 1'b0;
        check("fill_busy", 32'(busy), 32'd1);
        check("fill_first_addr", 32'(mem_addr), 32'd0);
        check("fill_first_wdata", 32'(mem_wdata), 32'h7F81);
        n = 0;
        while (!fill_done && n < 20) begin
            tick();
            n++;
        end
        check("fill_done_seen", 32'(fill_done), 32'd1);
        check("fill_we_cycles", 32'(we_cnt - pre_we), 32'd8);
        tick();
        check("fill_done_pulse", 32'(fill_done), 32'd0);
        check("fill_idle", 32'(busy), 32'd0);
        check("fill_done_count", 32'(done_cnt - pre_done), 32'd1);
        for (int a = 0; a < 8; a++) begin
            send(1'b0, ADDR_W'(a), '0, 15'h7F81, 1'b0, lat);
            check("fill_rd_latency", 32'(lat), 32'd2);
            tick();
        end

        // Back-pressure: response held, no new access while stalled.
        bus.rsp_ready = 1'b0;
        send(1'b0, 3'd2, '0, 15'h7F81, 1'b0, lat);
        pre_we        = we_cnt;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = 3'd6;
        bus.cmd_wdata = 15'h2222;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("stall_valid", 32'(bus.rsp_valid), 32'd1);
            check("stall_rdata", 32'(bus.rsp_rdata), 32'h7F81);
            check("stall_err", 32'(bus.rsp_err), 32'd0);
            check("stall_cmd_ready", 32'(bus.cmd_ready), 32'd0);
            check("stall_mem_we", 32'(mem_we), 32'd0);
            check("stall_mem_addr", 32'(mem_addr), 32'd2);
        end
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        tick();
        check("stall_release", 32'(bus.rsp_valid), 32'd0);
        check("stall_no_we", 32'(we_cnt - pre_we), 32'd0);
        tick();

        // Write-verify errors with the memory read path forced to zero.
        force_zero = 1'b1;
        send(1'b1, 3'd1, 15'h1381, 15'h0000, 1'b1, lat);
        tick();
        check("err_count_one", 32'(err_count), 32'd1);
        for (int k = 0; k < 299; k++) begin
            send(1'b1, 3'd1, 15'h1381, 15'h0000, 1'b1, lat);
            tick();
        end
        check("err_count_sat", 32'(err_count), 32'd255);
        force_zero = 1'b0;

        // Reset while the fill is writing address 4.
        pre_done   = done_cnt;
        fill_value = 15'h5555;
        fill_start = 1'b1;
        tick();
        fill_start = 1'b0;
        n = 0;
        while (!(mem_we && mem_addr == 3'd4) && n < 20) begin
            tick();
            n++;
        end
        check("fill_at_addr4", 32'(mem_addr), 32'd4);
        rst = 1'b1;
        tick();
        check("rstfill_mem_we", 32'(mem_we), 32'd0);
        check("rstfill_busy", 32'(busy), 32'd0);
        check("rstfill_done", 32'(fill_done), 32'd0);
        check("rstfill_err_count", 32'(err_count), 32'd0);
        rst = 1'b0;
        #1;
        check("rstfill_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        repeat (10) tick();
        check("rstfill_no_done", 32'(done_cnt - pre_done), 32'd0);
        check("rstfill_no_rsp", 32'(sb_q.size()), 32'd0);
        send(1'b0, 3'd4, '0, 15'h0000, 1'b0, lat);
        check("post_rst_latency", 32'(lat), 32'd2);
        tick();
        send(1'b0, 3'd1, '0, 15'h0000, 1'b0, lat);
        tick();
        tick();
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
